// File: rtl/reg_vec_serializer.sv
// Parallel-to-serial converter: captures a LANES x WIDTH vector, then emits lane 0 first.
// Optional macro REG_VEC_SER_PIPE_EN allows a new capture on the last beat (zero-bubble).
//
// state  | meaning
// S_IDLE | waiting for an input vector, in_ready high once out of reset
// S_SEND | streaming shadow lanes, one per accepted output beat
module reg_vec_serializer #(
  parameter int WIDTH = 3,
  parameter int LANES = 3,
  localparam int IDXW = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_vec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [IDXW-1:0]        out_idx,
  output logic                   out_last
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LANES - 1);

  logic [0:0]             r_state;
  logic                   r_alive;
  logic [IDXW-1:0]        r_idx;
  logic [LANES*WIDTH-1:0] r_shadow;

  logic             w_send;
  logic             w_last_idx;
  logic             w_beat;
  logic             w_in_ready;
  logic             w_capture;
  logic [WIDTH-1:0] w_lane;

  assign w_send     = (r_state == S_SEND);
  assign w_last_idx = (r_idx == LAST_IDX);
  assign w_beat     = w_send && out_ready;

  // r_alive keeps in_ready low for the cycle in which reset was sampled high
`ifdef REG_VEC_SER_PIPE_EN
  assign w_in_ready = ((r_state == S_IDLE) && r_alive) || (w_send && w_last_idx && out_ready);
`else
  assign w_in_ready = (r_state == S_IDLE) && r_alive;
`endif

  assign w_capture = in_valid && w_in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_alive  <= 1'b0;
      r_idx    <= '0;
      r_shadow <= '0;
    end else begin
      r_alive <= 1'b1;
      if (w_capture) begin
        r_shadow <= in_vec;
        r_idx    <= '0;
        r_state  <= S_SEND;
      end else if (w_beat) begin
        if (w_last_idx) begin
          r_idx   <= '0;
          r_state <= S_IDLE;
        end else begin
          r_idx <= r_idx + IDXW'(1);
        end
      end
    end
  end

  always_comb begin
    w_lane = '0;
    for (int k = 0; k < LANES; k++) begin
      if (r_idx == k[IDXW-1:0]) w_lane = r_shadow[k*WIDTH +: WIDTH];
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_send;
  assign out_data  = w_send ? w_lane : '0;
  assign out_idx   = r_idx;
  assign out_last  = w_send && w_last_idx;

endmodule

// File: tb/tb_reg_vec_serializer.sv
// Self-checking bench for reg_vec_serializer: directed scenarios plus random traffic
// against a queue-based beat model; honours REG_VEC_SER_PIPE_EN when defined.
module tb_reg_vec_serializer;
  localparam int W  = 3;
  localparam int L  = 3;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [L*W-1:0] in_vec;
  logic [W-1:0]   out_data;
  logic [IW-1:0]  out_idx;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [IW-1:0] idx;
    logic          last;
  } beat_t;

  beat_t          q[$];
  logic [L*W-1:0] pend[$];
  int             beat_cyc[$];
  int             cyc = 0;
  int             total = 0;
  int             bad = 0;
  bit             rst_q = 1'b1;
  bit             started = 1'b0;

  always #5 clk = ~clk;

  reg_vec_serializer #(.WIDTH(W), .LANES(L)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after negedge, check outputs, advance the model.
  task automatic step(input logic rst, input logic ordy);
    bit exp_rdy, exp_v;
    @(negedge clk);
    reset     = rst;
    out_ready = ordy;
    in_valid  = (pend.size() > 0);
    in_vec    = (pend.size() > 0) ? pend[0] : L*W'($urandom);
    #1;
    exp_v = (q.size() > 0);
`ifdef REG_VEC_SER_PIPE_EN
    exp_rdy = !rst_q && ((q.size() == 0) || (q.size() == 1 && ordy));
`else
    exp_rdy = !rst_q && (q.size() == 0);
`endif
    if (started) begin
      chk("in_ready", in_ready, exp_rdy);
      chk("out_valid", out_valid, exp_v);
      if (exp_v) begin
        chk("out_data", out_data, q[0].d);
        chk("out_idx", out_idx, q[0].idx);
        chk("out_last", out_last, q[0].last);
      end else begin
        chk("out_last_idle", out_last, 1'b0);
      end
      if (rst_q) chk("out_data_rst", out_data, '0);
    end
    if (rst) begin
      q.delete();
      rst_q = 1'b1;
    end else begin
      if (exp_v && ordy) begin
        void'(q.pop_front());
        beat_cyc.push_back(cyc);
      end
      if (exp_rdy && in_valid) begin
        for (int k = 0; k < L; k++) begin
          beat_t b;
          b.d    = in_vec[k*W +: W];
          b.idx  = IW'(k);
          b.last = (k == L - 1);
          q.push_back(b);
        end
        void'(pend.pop_front());
      end
      rst_q = 1'b0;
    end
    started = 1'b1;
    cyc++;
  endtask

  initial begin
    int n;
    int gap;
    reset = 1'b1; out_ready = 1'b0; in_valid = 1'b0; in_vec = '0;

    // reset held, then released
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // basic vector, sink always ready
    beat_cyc.delete();
    pend.push_back({3'd5, 3'd2, 3'd7});
    repeat (6) step(1'b0, 1'b1);
    chk("basic_cnt", beat_cyc.size(), 3);
    chk("basic_consec", beat_cyc[2] - beat_cyc[0], 2);

    // stall on idx1 for 4 cycles
    beat_cyc.delete();
    pend.push_back({3'd5, 3'd2, 3'd7});
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1);
    chk("stall_cnt", beat_cyc.size(), 3);

    // back-to-back vectors with in_valid held
    beat_cyc.delete();
    pend.push_back({3'd3, 3'd2, 3'd1});
    pend.push_back({3'd6, 3'd5, 3'd4});
    repeat (10) step(1'b0, 1'b1);
`ifdef REG_VEC_SER_PIPE_EN
    gap = 1;
`else
    gap = 2;
`endif
    chk("b2b_cnt", beat_cyc.size(), 6);
    chk("b2b_gap", beat_cyc[3] - beat_cyc[2], gap);
    chk("b2b_span", beat_cyc[5] - beat_cyc[0], 4 + gap);

    // reset after beat idx0, then a fresh vector
    pend.push_back({3'd1, 3'd2, 3'd3});
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    pend.push_back({3'd0, 3'd0, 3'd6});
    repeat (6) step(1'b0, 1'b1);

    // random traffic with occasional resets and back-pressure
    repeat (400) begin
      if (pend.size() < 2 && $urandom_range(0, 2) == 0) pend.push_back(L*W'($urandom));
      step($urandom_range(0, 99) < 2, $urandom_range(0, 3) != 0);
    end

    n = 0;
    while ((q.size() > 0 || pend.size() > 0) && n < 60) begin
      step(1'b0, 1'b1);
      n++;
    end
    chk("drain", q.size() + pend.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
